// File: rtl/controle_multiplicador_pkg.sv
// Shared definitions for the ULA multiplier control stage: FSM state
// encodings, default operand width and counter widths.
package controle_multiplicador_pkg;

    // Default operand width; the product is twice as wide.
    localparam int LARGURA_PADRAO = 4;

    // Width of the completed-operation counter reported to the status path.
    localparam int LARGURA_CONTADOR_OPS = 8;

    // Width of the settle-time down-counter (settle range 0..15).
    localparam int LARGURA_ESPERA = 4;

    // Control states. The ST_ prefix keeps the literals apart from the
    // ESPERA settle-time parameter of the top module.
    typedef enum logic [1:0] {
        ST_OCIOSO  = 2'd0,
        ST_ESPERA  = 2'd1,
        ST_ENTREGA = 2'd2
    } estado_t;

endpackage : controle_multiplicador_pkg

// File: rtl/contador_espera.sv
// Loadable down-counter that times the multiplier settle interval.
// A load wins over a decrement, the count saturates at zero and the zero
// flag is combinational from the count.
module contador_espera
    import controle_multiplicador_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      carregar,
    input  logic [LARGURA_ESPERA-1:0] valor,
    input  logic                      decrementar,
    output logic                      zero
);

    logic [LARGURA_ESPERA-1:0] contagem;

    // Count register: load on operand acceptance, otherwise count down to zero.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= valor;
        end else if (decrementar && (contagem != '0)) begin
            contagem <= contagem - 1'b1;
        end
    end

    assign zero = (contagem == '0);

endmodule : contador_espera

// File: rtl/controle_multiplicador.sv
// Sequencing/registering stage around the external combinational array
// multiplier of the 8-bit ULA. Operands arrive over a valid/ready handshake,
// are held on mult_a/mult_b, the product is captured after ESPERA settle
// cycles and offered over a second valid/ready handshake. A wrap-around
// counter tracks delivered operations.
// Optional build macro: ATALHO_ZERO_EN -- a pair with a zero operand skips
// the settle wait and delivers a zero product at the acceptance edge.
module controle_multiplicador
    import controle_multiplicador_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int ESPERA  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valido,
    output logic                            in_pronto,
    input  logic [LARGURA-1:0]              in_a,
    input  logic [LARGURA-1:0]              in_b,
    output logic [LARGURA-1:0]              mult_a,
    output logic [LARGURA-1:0]              mult_b,
    input  logic [2*LARGURA-1:0]            mult_s,
    output logic                            out_valido,
    input  logic                            out_pronto,
    output logic [2*LARGURA-1:0]            out_produto,
    output logic                            ocupado,
    output logic [LARGURA_CONTADOR_OPS-1:0] contador_ops
);

    localparam logic [LARGURA_ESPERA-1:0] ESPERA_CARGA = LARGURA_ESPERA'(ESPERA);

    estado_t estado, estado_prox;

    logic aceita;   // operand pair taken this edge
    logic captura;  // settled product captured this edge
    logic entrega;  // product handed to the consumer this edge
    logic atalho;   // zero-operand shortcut taken this edge
    logic espera_zero;

    // Settle-time counter, loaded with ESPERA whenever a pair is accepted.
    contador_espera u_contador_espera (
        .clk         (clk),
        .rst_n       (rst_n),
        .carregar    (aceita),
        .valor       (ESPERA_CARGA),
        .decrementar (estado == ST_ESPERA),
        .zero        (espera_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= ST_OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state and datapath strobes.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        estado_prox = estado;
        aceita      = 1'b0;
        captura     = 1'b0;
        entrega     = 1'b0;
        atalho      = 1'b0;
        case (estado)
            ST_OCIOSO: begin
                if (in_valido) begin
                    aceita = 1'b1;
`ifdef ATALHO_ZERO_EN
                    if ((in_a == '0) || (in_b == '0)) begin
                        atalho      = 1'b1;
                        estado_prox = ST_ENTREGA;
                    end else begin
                        estado_prox = ST_ESPERA;
                    end
`else
                    estado_prox = ST_ESPERA;
`endif
                end
            end
            ST_ESPERA: begin
                if (espera_zero) begin
                    captura     = 1'b1;
                    estado_prox = ST_ENTREGA;
                end
            end
            ST_ENTREGA: begin
                if (out_pronto) begin
                    entrega     = 1'b1;
                    estado_prox = ST_OCIOSO;
                end
            end
            default: begin
                estado_prox = ST_OCIOSO;
            end
        endcase
    end

    // Upstream may only hand over operands while idle; there is no overlap.
    assign in_pronto = (estado == ST_OCIOSO);
    assign ocupado   = (estado != ST_OCIOSO);

    // Operand, product, valid and operation-count registers.
    // NOTE: these are plain control/data flops, so all of them take the
    // async reset; a pending product must not survive a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a       <= '0;
            mult_b       <= '0;
            out_produto  <= '0;
            out_valido   <= 1'b0;
            contador_ops <= '0;
        end else begin
            // Operands stay on the multiplier after delivery.
            if (aceita) begin
                mult_a <= in_a;
                mult_b <= in_b;
            end
            if (captura) begin
                out_produto <= mult_s;
                out_valido  <= 1'b1;
            end
            if (atalho) begin
                out_produto <= '0;
                out_valido  <= 1'b1;
            end
            if (entrega) begin
                out_valido   <= 1'b0;
                contador_ops <= contador_ops + 1'b1;
            end
        end
    end

endmodule : controle_multiplicador

// File: tb/tb_controle_multiplicador.sv
// Directed bench for controle_multiplicador. Two instances share clock and
// reset: one with ESPERA=1, one with ESPERA=0. Each has its own behavioural
// multiplier driving mult_s.
module tb_controle_multiplicador;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance with ESPERA = 1.
    logic       in_valido1 = 1'b0, out_pronto1 = 1'b0;
    logic [3:0] in_a1 = '0, in_b1 = '0;
    logic       in_pronto1, out_valido1, ocupado1;
    logic [3:0] mult_a1, mult_b1;
    logic [7:0] mult_s1, out_produto1, contador_ops1;

    assign mult_s1 = {4'h0, mult_a1} * {4'h0, mult_b1};

    controle_multiplicador #(.LARGURA(4), .ESPERA(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valido    (in_valido1),
        .in_pronto    (in_pronto1),
        .in_a         (in_a1),
        .in_b         (in_b1),
        .mult_a       (mult_a1),
        .mult_b       (mult_b1),
        .mult_s       (mult_s1),
        .out_valido   (out_valido1),
        .out_pronto   (out_pronto1),
        .out_produto  (out_produto1),
        .ocupado      (ocupado1),
        .contador_ops (contador_ops1)
    );

    // Instance with ESPERA = 0.
    logic       in_valido0 = 1'b0, out_pronto0 = 1'b0;
    logic [3:0] in_a0 = '0, in_b0 = '0;
    logic       in_pronto0, out_valido0, ocupado0;
    logic [3:0] mult_a0, mult_b0;
    logic [7:0] mult_s0, out_produto0, contador_ops0;

    assign mult_s0 = {4'h0, mult_a0} * {4'h0, mult_b0};

    controle_multiplicador #(.LARGURA(4), .ESPERA(0)) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valido    (in_valido0),
        .in_pronto    (in_pronto0),
        .in_a         (in_a0),
        .in_b         (in_b0),
        .mult_a       (mult_a0),
        .mult_b       (mult_b0),
        .mult_s       (mult_s0),
        .out_valido   (out_valido0),
        .out_pronto   (out_pronto0),
        .out_produto  (out_produto0),
        .ocupado      (ocupado0),
        .contador_ops (contador_ops0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] a, b;

        // Reset and idle.
        tick();
        tick();
        check("rst out_valido", 16'(out_valido1), 16'h0);
        check("rst out_produto", 16'(out_produto1), 16'h0);
        check("rst mult_a", 16'(mult_a1), 16'h0);
        check("rst mult_b", 16'(mult_b1), 16'h0);
        check("rst contador", 16'(contador_ops1), 16'h0);
        check("rst in_pronto", 16'(in_pronto1), 16'h1);
        check("rst ocupado", 16'(ocupado1), 16'h0);
        rst_n = 1'b1;
        tick();
        check("idle in_pronto", 16'(in_pronto1), 16'h1);
        check("idle ocupado", 16'(ocupado1), 16'h0);

        // Reset pulsed while in ESPERA discards the operation.
        in_valido1 = 1'b1; in_a1 = 4'h2; in_b1 = 4'h3;
        tick();
        in_valido1 = 1'b0;
        check("mid accepted ocupado", 16'(ocupado1), 16'h1);
        check("mid mult_a", 16'(mult_a1), 16'h2);
        rst_n = 1'b0;
        #1;
        check("mid rst ocupado", 16'(ocupado1), 16'h0);
        check("mid rst in_pronto", 16'(in_pronto1), 16'h1);
        check("mid rst out_valido", 16'(out_valido1), 16'h0);
        check("mid rst mult_a", 16'(mult_a1), 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("mid after out_valido", 16'(out_valido1), 16'h0);
        check("mid after contador", 16'(contador_ops1), 16'h0);

        // ESPERA=1: F*F, product valid two edges after acceptance.
        out_pronto1 = 1'b1;
        in_valido1 = 1'b1; in_a1 = 4'hF; in_b1 = 4'hF;
        tick();  // T
        in_valido1 = 1'b0;
        check("ff T in_pronto", 16'(in_pronto1), 16'h0);
        check("ff T mult_a", 16'(mult_a1), 16'hF);
        check("ff T out_valido", 16'(out_valido1), 16'h0);
        tick();  // T+1
        check("ff T+1 out_valido", 16'(out_valido1), 16'h0);
        tick();  // T+2
        check("ff T+2 out_valido", 16'(out_valido1), 16'h1);
        check("ff T+2 produto", 16'(out_produto1), 16'h00E1);
        tick();  // handshake edge
        check("ff hs out_valido", 16'(out_valido1), 16'h0);
        check("ff hs contador", 16'(contador_ops1), 16'h1);
        check("ff hs in_pronto", 16'(in_pronto1), 16'h1);

        // ESPERA=0: 3*5 with consumer stalled; pending pair must be ignored.
        in_valido0 = 1'b1; in_a0 = 4'h3; in_b0 = 4'h5;
        tick();  // T
        in_a0 = 4'h6; in_b0 = 4'h2;  // in_valido0 held high
        tick();  // T+1
        check("st T+1 out_valido", 16'(out_valido0), 16'h1);
        check("st T+1 produto", 16'(out_produto0), 16'h000F);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("st hold produto", 16'(out_produto0), 16'h000F);
            check("st hold out_valido", 16'(out_valido0), 16'h1);
            check("st hold in_pronto", 16'(in_pronto0), 16'h0);
            check("st hold mult_a", 16'(mult_a0), 16'h3);
        end
        out_pronto0 = 1'b1;
        tick();  // delivery
        check("st hs out_valido", 16'(out_valido0), 16'h0);
        check("st hs contador", 16'(contador_ops0), 16'h1);
        check("st hs in_pronto", 16'(in_pronto0), 16'h1);
        check("st hs mult_a kept", 16'(mult_a0), 16'h3);
        tick();  // 6*2 accepted
        in_valido0 = 1'b0;
        check("st new mult_a", 16'(mult_a0), 16'h6);
        check("st new mult_b", 16'(mult_b0), 16'h2);
        tick();
        check("st new produto", 16'(out_produto0), 16'h000C);
        check("st new out_valido", 16'(out_valido0), 16'h1);
        tick();
        check("st new contador", 16'(contador_ops0), 16'h2);

        // Back-to-back operations until the counter wraps (256 total).
        for (int i = 0; i < 254; i++) begin
            a = 4'((i % 15) + 1);
            b = 4'(((i * 7) % 15) + 1);
            in_valido0 = 1'b1; in_a0 = a; in_b0 = b;
            tick();  // accept
            in_valido0 = 1'b0;
            tick();  // capture
            check("b2b produto", 16'(out_produto0), 16'({4'h0, a} * {4'h0, b}));
            tick();  // handshake
            if (i == 252) check("b2b contador FF", 16'(contador_ops0), 16'h00FF);
        end
        check("b2b contador wrap", 16'(contador_ops0), 16'h0000);

        // Zero operand on the ESPERA=1 instance (previous product was E1).
        in_valido1 = 1'b1; in_a1 = 4'h0; in_b1 = 4'h9;
        tick();  // T
        in_valido1 = 1'b0;
        check("zero T mult_b", 16'(mult_b1), 16'h9);
`ifdef ATALHO_ZERO_EN
        check("zero T out_valido", 16'(out_valido1), 16'h1);
        check("zero T produto", 16'(out_produto1), 16'h0000);
`else
        check("zero T out_valido", 16'(out_valido1), 16'h0);
        tick();
        check("zero T+1 out_valido", 16'(out_valido1), 16'h0);
        tick();
        check("zero T+2 out_valido", 16'(out_valido1), 16'h1);
        check("zero T+2 produto", 16'(out_produto1), 16'h0000);
`endif
        tick();  // handshake (out_pronto1 still high)
        check("zero hs out_valido", 16'(out_valido1), 16'h0);
        check("zero hs contador", 16'(contador_ops1), 16'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_controle_multiplicador
